compute_unit_pipe: RTL and testbench

//  Parametrised successor compute unit: NUM_REGS x DATA_W register file plus ALU behind a 2-stage pipeline.

---
 rtl/compute_unit_pkg.sv | 34 +++
 rtl/compute_unit_pipe_alu.sv | 57 +++++
 rtl/compute_unit_pipe.sv | 147 ++++++++++++++
 tb/tb_compute_unit_pipe.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compute_unit_pkg.sv
// Shared definitions for the compute unit: opcodes, flag bit positions, width helpers.
// No logic; pure constants and constant functions.
// Used by the ALU and the pipeline top.
package compute_unit_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_SHL  = 4'h1;
   localparam logic [3:0] OP_SHR  = 4'h2;
   localparam logic [3:0] OP_MOV  = 4'h3;
   localparam logic [3:0] OP_LOAD = 4'h9;
   localparam logic [3:0] OP_ADD  = 4'hA;
   localparam logic [3:0] OP_SUB  = 4'hB;
   localparam logic [3:0] OP_AND  = 4'hC;
   localparam logic [3:0] OP_OR   = 4'hD;
   localparam logic [3:0] OP_NOT  = 4'hE;
   localparam logic [3:0] OP_XOR  = 4'hF;

   // out_flags = {illegal, negative, carry, zero}
   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_NEG   = 2;
   localparam int FLAG_ILL   = 3;

   // Register-index width for a power-of-two register count.
   function automatic int ra_width(input int num_regs);
      return $clog2(num_regs);
   endfunction

   // Opcode + target + payload, payload wide enough for an immediate or two source indices.
   function automatic int instr_width(input int data_w, input int ra_w);
      return 4 + ra_w + ((data_w > 2 * ra_w) ? data_w : 2 * ra_w);
   endfunction

endpackage

// File: rtl/compute_unit_pipe_alu.sv
// Combinational ALU: op, operands and immediate in; result, carry, illegal and write-enable out.
// Latency: zero (purely combinational).
// Backpressure: none; the pipeline decides when the result is consumed.
module cu_alu
   import compute_unit_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] imm,
   output logic [DATA_W-1:0] result,
   output logic              carry,
   output logic              illegal,
   output logic              wb
);

   localparam int SH_W = $clog2(DATA_W);

   logic [SH_W-1:0] amt;
   logic [DATA_W:0] shl_ext;
   logic [DATA_W:0] shr_ext;
   logic [DATA_W:0] add_ext;
   logic [DATA_W:0] sub_ext;

   // Extended shifts leave the last bit shifted out in the spare bit position;
   // the extended subtract leaves the borrow in the top bit.
   assign amt     = b[SH_W-1:0];
   assign shl_ext = {1'b0, a} << amt;
   assign shr_ext = {a, 1'b0} >> amt;
   assign add_ext = {1'b0, a} + {1'b0, b};
   assign sub_ext = {1'b0, a} - {1'b0, b};

   // Opcode decode; NOP and illegal opcodes produce zero and suppress writeback.
   always_comb begin
      result  = '0;
      carry   = 1'b0;
      illegal = 1'b0;
      wb      = 1'b1;
      case (op)
         OP_NOP:  wb = 1'b0;
         OP_SHL:  begin result = shl_ext[DATA_W-1:0]; carry = shl_ext[DATA_W]; end
         OP_SHR:  begin result = shr_ext[DATA_W:1];   carry = shr_ext[0];      end
         OP_MOV:  result = a;
         OP_LOAD: result = imm;
         OP_ADD:  begin result = add_ext[DATA_W-1:0]; carry = add_ext[DATA_W]; end
         OP_SUB:  begin result = sub_ext[DATA_W-1:0]; carry = sub_ext[DATA_W]; end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         default: begin illegal = 1'b1; wb = 1'b0; end
      endcase
   end

endmodule

// File: rtl/compute_unit_pipe.sv
// Register file + ALU behind a 2-stage pipeline (S1 latched operands, S2 output register).
// Latency: 2 cycles from accept to out_valid; one instruction per cycle sustained.
// Backpressure: out_valid&!out_ready holds S2; in_ready drops only when S1 is also full.
module compute_unit_pipe
   import compute_unit_pkg::*;
#(
   parameter  int DATA_W   = 8,
   parameter  int NUM_REGS = 16,
   localparam int RA_W     = ra_width(NUM_REGS),
   localparam int INSTR_W  = instr_width(DATA_W, RA_W)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  out_data,
   output logic [RA_W-1:0]    out_tgt,
   output logic [3:0]         out_flags
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   logic [3:0]        in_op;
   logic [RA_W-1:0]   in_tgt;
   logic [RA_W-1:0]   in_src0;
   logic [RA_W-1:0]   in_src1;
   logic [DATA_W-1:0] in_imm;

   logic              alive;
   logic              s1_valid;
   logic [3:0]        s1_op;
   logic [RA_W-1:0]   s1_tgt;
   logic [DATA_W-1:0] s1_a;
   logic [DATA_W-1:0] s1_b;
   logic [DATA_W-1:0] s1_imm;

   logic [DATA_W-1:0] alu_res;
   logic              alu_carry;
   logic              alu_ill;
   logic              alu_wb;

   logic              s2_stall;
   logic              s1_adv;
   logic              wb_fire;
   logic              accept;
   logic [DATA_W-1:0] rd_a;
   logic [DATA_W-1:0] rd_b;
   logic [3:0]        nxt_flags;

   assign in_op   = in_instr[INSTR_W-1 -: 4];
   assign in_tgt  = in_instr[INSTR_W-5 -: RA_W];
   assign in_src0 = in_instr[2*RA_W-1 -: RA_W];
   assign in_src1 = in_instr[RA_W-1:0];
   assign in_imm  = in_instr[DATA_W-1:0];

   assign s2_stall = out_valid & ~out_ready;
   assign s1_adv   = ena & s1_valid & ~s2_stall;
   assign wb_fire  = s1_adv & alu_wb;
   assign in_ready = alive & ena & ~(s1_valid & s2_stall);
   assign accept   = in_valid & in_ready;

   cu_alu #(.DATA_W(DATA_W)) u_alu (
      .op      (s1_op),
      .a       (s1_a),
      .b       (s1_b),
      .imm     (s1_imm),
      .result  (alu_res),
      .carry   (alu_carry),
      .illegal (alu_ill),
      .wb      (alu_wb)
   );

   // Operand read; a source matching the register written back at this edge takes the new value.
   always_comb begin
      rd_a = regs[in_src0];
      rd_b = regs[in_src1];
      if (wb_fire && (s1_tgt == in_src0)) rd_a = alu_res;
      if (wb_fire && (s1_tgt == in_src1)) rd_b = alu_res;
   end

   // Flags for the result entering the output register.
   always_comb begin
      nxt_flags             = '0;
      nxt_flags[FLAG_ZERO]  = (alu_res == '0);
      nxt_flags[FLAG_CARRY] = alu_carry;
      nxt_flags[FLAG_NEG]   = alu_res[DATA_W-1];
      nxt_flags[FLAG_ILL]   = alu_ill;
   end

   // Holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive <= 1'b0;
      else        alive <= 1'b1;
   end

   // Register file; written only as the result moves into the output register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_fire) begin
         regs[s1_tgt] <= alu_res;
      end
   end

   // S1: latch decoded instruction and operands on accept, empty when it advances.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_op    <= '0;
         s1_tgt   <= '0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_imm   <= '0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_op    <= in_op;
         s1_tgt   <= in_tgt;
         s1_a     <= rd_a;
         s1_b     <= rd_b;
         s1_imm   <= in_imm;
      end else if (s1_adv) begin
         s1_valid <= 1'b0;
      end
   end

   // S2: output register, frozen while the consumer stalls or ena is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_tgt   <= '0;
         out_flags <= '0;
      end else if (ena && !s2_stall) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data  <= alu_res;
            out_tgt   <= s1_tgt;
            out_flags <= nxt_flags;
         end
      end
   end

endmodule

// File: tb/tb_compute_unit_pipe.sv
// Directed bench for compute_unit_pipe with an architectural reference model and scoreboard.
// The model executes each instruction in program order at the moment it is accepted.
// A compare process checks every presented beat against the head of the expected queue.
module tb_compute_unit_pipe;

   localparam int DW = 8;
   localparam int NR = 16;
   localparam int RW = 4;
   localparam int IW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] in_instr = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_data;
   logic [RW-1:0] out_tgt;
   logic [3:0]    out_flags;

   always #5 clk = ~clk;

   compute_unit_pipe #(.DATA_W(DW), .NUM_REGS(NR)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tgt   (out_tgt),
      .out_flags (out_flags)
   );

   int            n_tests = 0;
   int            n_fail  = 0;
   int            n_acc   = 0;
   logic [DW-1:0] mdl_regs [NR];
   logic [15:0]   exp_q [$];
   logic [DW-1:0] last_data  = '0;
   logic [3:0]    last_flags = '0;
   time           t_last = 0;
   time           t_prev = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [IW-1:0] rr(input logic [3:0] op, input logic [3:0] t,
                                        input logic [3:0] s0, input logic [3:0] s1);
      return {op, t, s0, s1};
   endfunction

   function automatic logic [IW-1:0] ld(input logic [3:0] t, input logic [7:0] imm);
      return {4'h9, t, imm};
   endfunction

   // Architectural meaning of one instruction: read, compute, write, expect one beat.
   task automatic model_accept(input logic [IW-1:0] ins);
      logic [3:0] op;
      logic [3:0] t;
      int         ia;
      int         ib;
      int         amt;
      int         r;
      logic       c;
      logic       ill;
      logic       wb;
      logic [7:0] res;
      op  = ins[15:12];
      t   = ins[11:8];
      ia  = 32'(mdl_regs[ins[7:4]]);
      ib  = 32'(mdl_regs[ins[3:0]]);
      amt = ib % DW;
      r   = 0;
      c   = 1'b0;
      ill = 1'b0;
      wb  = 1'b1;
      case (op)
         4'h0: wb = 1'b0;
         4'h1: begin r = ia << amt; c = r[8]; end
         4'h2: begin r = ia >> amt; c = (amt == 0) ? 1'b0 : ia[amt-1]; end
         4'h3: r = ia;
         4'h9: r = 32'(ins[7:0]);
         4'hA: begin r = ia + ib; c = r[8]; end
         4'hB: begin r = ia - ib; c = (ia < ib); end
         4'hC: r = ia & ib;
         4'hD: r = ia | ib;
         4'hE: r = ~ia;
         4'hF: r = ia ^ ib;
         default: begin ill = 1'b1; wb = 1'b0; end
      endcase
      res = r[7:0];
      if (wb) mdl_regs[t] = res;
      exp_q.push_back({ill, res[7], c, (res == 8'h00), t, res});
   endtask

   task automatic send(input logic [IW-1:0] ins);
      int w;
      w = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_instr = ins;
      #1;
      while (!in_ready && w < 50) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!in_ready) begin
         chk("send_timeout", 32'(in_ready), 1);
         in_valid = 1'b0;
      end else begin
         model_accept(ins);
         n_acc++;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() > 0 && w < 100) begin
         @(negedge clk);
         w++;
      end
      chk("drain", 32'(exp_q.size()), 0);
      #3;
   endtask

   // Scoreboard: every presented beat must equal the oldest outstanding expectation.
   always @(negedge clk) begin
      #2;
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(out_valid), 0);
         end else begin
            chk("beat", 32'({out_flags, out_tgt, out_data}), 32'(exp_q[0]));
            if (out_ready && ena) begin
               last_data  = out_data;
               last_flags = out_flags;
               t_prev     = t_last;
               t_last     = $time;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
      ena = 1'b1;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data",  32'(out_data), 0);
      chk("rst_out_tgt",   32'(out_tgt), 0);
      chk("rst_out_flags", 32'(out_flags), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 1);

      // 0x0F + 0xF1 wraps to zero with carry
      send(ld(4'd1, 8'h0F));
      send(ld(4'd2, 8'hF1));
      send(rr(4'hA, 4'd3, 4'd1, 4'd2));
      drain();
      chk("add_wrap_data",  32'(last_data), 'h00);
      chk("add_wrap_flags", 32'(last_flags), 'b0011);

      // dependent op immediately behind its producer, no bubble
      send(ld(4'd4, 8'd5));
      send(rr(4'hA, 4'd5, 4'd4, 4'd4));
      drain();
      chk("fwd_add_data", 32'(last_data), 'h0A);
      chk("fwd_no_bubble", 32'(t_last - t_prev), 10);

      send(rr(4'hB, 4'd6, 4'd1, 4'd2));
      drain();
      chk("sub_data",  32'(last_data), 'h1E);
      chk("sub_flags", 32'(last_flags), 'b0010);
      send(ld(4'd8, 8'd1));
      send(rr(4'h1, 4'd7, 4'd2, 4'd8));
      drain();
      chk("shl_data",  32'(last_data), 'hE2);
      chk("shl_flags", 32'(last_flags), 'b0110);

      // consumer stall with three instructions offered
      @(negedge clk);
      out_ready = 1'b0;
      n_acc = 0;
      fork
         begin
            send(rr(4'hA, 4'd9, 4'd1, 4'd1));
            send(rr(4'hD, 4'd10, 4'd1, 4'd2));
            send(rr(4'hF, 4'd11, 4'd9, 4'd10));
         end
         begin
            repeat (4) @(negedge clk);
            #2;
            chk("stall_in_ready",  32'(in_ready), 0);
            chk("stall_accepted",  32'(n_acc), 2);
            chk("stall_out_valid", 32'(out_valid), 1);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_last_xor", 32'(last_data), 'hE1);

      // illegal opcode: one beat, nothing written
      send(rr(4'h5, 4'd4, 4'd1, 4'd2));
      drain();
      chk("illegal_data",  32'(last_data), 'h00);
      chk("illegal_flags", 32'(last_flags), 'b1001);
      send(rr(4'h3, 4'd12, 4'd4, 4'd0));
      drain();
      chk("illegal_no_write", 32'(last_data), 'h05);

      // freeze with ena low while stalled; tgt==src uses the old value
      @(negedge clk);
      out_ready = 1'b0;
      send(rr(4'hA, 4'd1, 4'd1, 4'd1));
      send(rr(4'hE, 4'd13, 4'd1, 4'd0));
      @(negedge clk);
      ena = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      chk("freeze_out_valid", 32'(out_valid), 1);
      chk("freeze_out_data",  32'(out_data), 'h1E);
      chk("freeze_in_ready",  32'(in_ready), 0);
      @(negedge clk);
      ena = 1'b1;
      out_ready = 1'b1;
      drain();
      chk("not_data",  32'(last_data), 'hE1);
      chk("not_flags", 32'(last_flags), 'b0100);

      send(rr(4'h2, 4'd14, 4'd2, 4'd8));
      send(rr(4'hC, 4'd15, 4'd2, 4'd4));
      drain();
      chk("and_data", 32'(last_data), 'h01);

      // reset with two instructions in flight
      send(ld(4'd3, 8'hAA));
      send(ld(4'd5, 8'h55));
      rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 0);
      chk("midrst_in_ready",  32'(in_ready), 0);
      exp_q.delete();
      for (int i = 0; i < NR; i++) mdl_regs[i] = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("midrst_out_flags", 32'(out_flags), 0);
      chk("midrst_out_data",  32'(out_data), 0);
      for (int i = 0; i < NR; i++) send(rr(4'h3, 4'(i), 4'(i), 4'd0));
      drain();
      chk("readback_last", 32'(last_data), 'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
